// File: rtl/rob_req_arbiter_pkg.sv
// Shared types and default sizing for the ROB request arbiter.
// The struct field widths follow the defaults here, so the top parameters must match them.
package rob_req_arbiter_pkg;

  localparam int NREQ     = 4;
  localparam int AWIDTH   = 4;
  localparam int SWIDTH   = 4;
  localparam int ROB_SIZE = 128;
  localparam int TIMEOUT  = 200;
  localparam int TAGW     = $clog2(ROB_SIZE);
  localparam int SRCW     = $clog2(NREQ);

  typedef logic [TAGW-1:0] rob_tag_t;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [SWIDTH-1:0] id;
  } req_buf_t;

  // A requester-side request extended with where it came from and the ROB tag it was given.
  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [SWIDTH-1:0] id;
    logic [SRCW-1:0]   src;
    rob_tag_t          tag;
  } mem_req_t;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } stage_state_t;

endpackage

// File: rtl/rob_req_arbiter_rr_arbiter.sv
// Round-robin grant: combinational search starting after the last winner,
// with the winner pointer updated only when the grant is actually taken.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            grant_en,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_vld
);

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] cand;

  // NREQ is a power of two, so the IDXW-bit sum wraps the search naturally.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + IDXW'(k);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDXW'(NREQ - 1);
    end else if (grant_en) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/rob_req_arbiter.sv
// Shares one memory request port between NREQ requesters, tags each issued request
// with an in-order ROB slot, and watches for a ROB that stops retiring.
module rob_req_arbiter #(
  parameter int NREQ     = rob_req_arbiter_pkg::NREQ,
  parameter int AWIDTH   = rob_req_arbiter_pkg::AWIDTH,
  parameter int SWIDTH   = rob_req_arbiter_pkg::SWIDTH,
  parameter int ROB_SIZE = rob_req_arbiter_pkg::ROB_SIZE,
  parameter int TAGW     = $clog2(ROB_SIZE),
  parameter int TIMEOUT  = rob_req_arbiter_pkg::TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_val,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*SWIDTH-1:0]   req_id,
  output logic [NREQ-1:0]          req_rdy,
  output logic                     mem_val,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic [SWIDTH-1:0]        mem_id,
  output logic [$clog2(NREQ)-1:0]  mem_src,
  output logic [TAGW-1:0]          mem_tag,
  input  logic                     mem_rdy,
  input  logic                     ret_val,
  output logic [TAGW:0]            outstanding,
  output logic                     rob_full,
  output logic                     timeout_err,
  output logic                     underflow_err
);

  import rob_req_arbiter_pkg::*;

  localparam int IDXW = $clog2(NREQ);
  localparam int WDW  = $clog2(TIMEOUT);

  stage_state_t    state_q, state_d;
  mem_req_t        stage_q;
  req_buf_t        sel_req;
  rob_tag_t        alloc_ptr;
  logic [TAGW:0]   out_cnt;
  logic [WDW-1:0]  wd_cnt;
  logic            timeout_q, underflow_q;

  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_vld;
  logic            stage_free, can_accept, accept, ret_ok, wd_inc;

  // The full check uses the registered count, so a same-cycle retire never unblocks an accept.
  assign stage_free = (state_q == ST_EMPTY) || mem_rdy;
  assign can_accept = stage_free && (out_cnt < (TAGW+1)'(ROB_SIZE));
  assign accept     = can_accept && grant_vld;
  assign req_rdy    = can_accept ? grant : '0;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_val),
    .grant_en  (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDXW'(i)) begin
        sel_req.addr = req_addr[i*AWIDTH +: AWIDTH];
        sel_req.id   = req_id[i*SWIDTH +: SWIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:  if (accept) state_d = ST_LOADED;
      ST_LOADED: if (mem_rdy && !accept) state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      stage_q   <= '0;
      alloc_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        stage_q   <= '{addr: sel_req.addr, id: sel_req.id, src: grant_idx, tag: alloc_ptr};
        alloc_ptr <= alloc_ptr + rob_tag_t'(1);
      end
    end
  end

  // A retire with nothing outstanding is dropped and only flagged.
  assign ret_ok = ret_val && (out_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt     <= '0;
      underflow_q <= 1'b0;
    end else begin
      case ({accept, ret_ok})
        2'b10:   out_cnt <= out_cnt + (TAGW+1)'(1);
        2'b01:   out_cnt <= out_cnt - (TAGW+1)'(1);
        default: out_cnt <= out_cnt;
      endcase
      if (ret_val && (out_cnt == '0)) underflow_q <= 1'b1;
    end
  end

  assign wd_inc = (out_cnt != '0) && !ret_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (!wd_inc) begin
      wd_cnt <= '0;
    end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
      timeout_q <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + WDW'(1);
    end
  end

  assign mem_val       = (state_q == ST_LOADED);
  assign mem_addr      = stage_q.addr;
  assign mem_id        = stage_q.id;
  assign mem_src       = stage_q.src;
  assign mem_tag       = stage_q.tag;
  assign outstanding   = out_cnt;
  assign rob_full      = (out_cnt == (TAGW+1)'(ROB_SIZE));
  assign timeout_err   = timeout_q;
  assign underflow_err = underflow_q;

endmodule
